// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS-style pipeline stages.
//
// Contents:
//   DW_DEF / RW_DEF   default datapath width and register-index width
//   alu_op_e          ALU opcode encoding used by the EX stage
//   mem_ctrl_t        the group of control bits carried from EX into MEM
package mips_pkg;

    localparam int DW_DEF   = 16;
    localparam int RW_DEF   = 3;
    localparam int ALU_OP_W = 3;

    // SLT and BNE produce no arithmetic result on ex_alu_out (it reads 0);
    // SLT takes its result from the less-than flag instead.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_BNE = 3'b101
    } alu_op_e;

    // Control bits registered into MEM. A bubble is all-zero.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } mem_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg -- one group of pipeline register bits.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, forces q to 0
//   en   in   load enable; when 0 the register holds
//   clr  in   when loading, load 0 instead of d (bubble insertion)
//   d    in   W  next value
//   q    out  W  registered value
//
// Priority is rst > en > clr, so a hold (en=0) also masks a clear.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= clr ? '0 : d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX/MEM pipeline register with branch redirect and
// overflow-trap handling.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold every register in this stage this cycle
//   flush                    squash the instruction in EX (capture a bubble)
//   ex_valid                 EX holds a real instruction
//   ex_alu_out [DW]          ALU result
//   ex_lt, ex_ne, ex_v       ALU less-than, not-equal, signed-overflow flags
//   ex_store_data [DW]       rt value for stores
//   ex_rd [RW]               destination register index
//   ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg   control bits
//   ex_slt, ex_bne, ex_trap_v                           op qualifiers
//   ex_pc, ex_br_target [DW] instruction PC, computed branch target
//   mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg
//                            registered MEM controls
//   mem_result, mem_store_data [DW], mem_rd [RW]   registered data
//   pc_redirect, redirect_target [DW]   one-captured-cycle branch-taken pulse
//   exc_flag, exc_pc [DW]    sticky overflow exception and first trapping PC
//
// Flow control: there is no valid/ready handshake here. stall=1 freezes the
// whole stage (including the redirect pulse and the exception latch) and
// wins over flush; when stall=0 every register loads on the rising edge.
// All outputs come straight from registers.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_out,
    input  logic          ex_lt,
    input  logic          ex_ne,
    input  logic          ex_v,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          ex_memtoreg,
    input  logic          ex_slt,
    input  logic          ex_bne,
    input  logic          ex_trap_v,
    input  logic [DW-1:0] ex_pc,
    input  logic [DW-1:0] ex_br_target,
    output logic          mem_valid,
    output logic          mem_regwrite,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic          mem_memtoreg,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          pc_redirect,
    output logic [DW-1:0] redirect_target,
    output logic          exc_flag,
    output logic [DW-1:0] exc_pc
);

    logic          capture;
    logic          ev;
    logic          br_taken;
    logic          ovf_trap;
    mem_ctrl_t     ctrl_d;
    mem_ctrl_t     ctrl_q;
    logic [DW-1:0] result_d;

    assign capture = ~stall;

    // The instruction sitting in EX while pc_redirect is high was fetched
    // down the wrong path, so it is squashed exactly like a flush.
    assign ev       = ex_valid & ~flush & ~pc_redirect;
    assign br_taken = ev & ex_bne & ex_ne;
    assign ovf_trap = ev & ex_trap_v & ex_v;

    // Branches never write registers or memory; a trapping instruction
    // must not commit its register or memory write.
    always_comb begin
        ctrl_d          = '0;
        ctrl_d.valid    = 1'b1;
        ctrl_d.regwrite = ex_regwrite & ~ex_bne & ~ovf_trap;
        ctrl_d.memread  = ex_memread  & ~ex_bne;
        ctrl_d.memwrite = ex_memwrite & ~ex_bne & ~ovf_trap;
        ctrl_d.memtoreg = ex_memtoreg;
    end

    // SLT writes the less-than flag zero-extended to the datapath width.
    always_comb begin
        result_d = ex_alu_out;
        if (ex_slt) begin
            result_d = {{(DW-1){1'b0}}, ex_lt};
        end
    end

    // Control group: cleared to a bubble whenever ev is low.
    pipe_reg #(
        .W($bits(mem_ctrl_t))
    ) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (~ev),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    assign mem_valid    = ctrl_q.valid;
    assign mem_regwrite = ctrl_q.regwrite;
    assign mem_memread  = ctrl_q.memread;
    assign mem_memwrite = ctrl_q.memwrite;
    assign mem_memtoreg = ctrl_q.memtoreg;

    // Data group: contents are meaningless behind a bubble, so it simply
    // loads every captured cycle.
    pipe_reg #(
        .W(2*DW + RW)
    ) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (1'b0),
        .d   ({result_d, ex_store_data, ex_rd}),
        .q   ({mem_result, mem_store_data, mem_rd})
    );

    // Redirect pulse: set by a taken branch, cleared by the next captured
    // edge that does not itself take a branch. While stalled it holds, so
    // the pulse stretches until the first non-stalled edge.
    pipe_reg #(
        .W(DW + 1)
    ) u_redirect_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (~br_taken),
        .d   ({1'b1, ex_br_target}),
        .q   ({pc_redirect, redirect_target})
    );

    // Exception latch: loads only for the first trap; afterwards it is
    // frozen until reset, which keeps exc_pc pointing at the first trap.
    pipe_reg #(
        .W(DW + 1)
    ) u_exc_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture & ovf_trap & ~exc_flag),
        .clr (1'b0),
        .d   ({1'b1, ex_pc}),
        .q   ({exc_flag, exc_pc})
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage -- self-checking bench for ex_mem_stage.
// Each scenario task drives EX inputs, pushes the expected MEM-side output
// word (plus a don't-care mask) onto a queue, and after the edge pops and
// compares against the DUT outputs.
module tb_ex_mem_stage;

    localparam int DW = 16;
    localparam int RW = 3;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic [DW-1:0] result;
        logic [DW-1:0] sdata;
        logic [RW-1:0] rd;
        logic          redir;
        logic [DW-1:0] tgt;
        logic          exc;
        logic [DW-1:0] epc;
    } out_t;

    localparam int OW = $bits(out_t);

    logic          clk;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_out;
    logic          ex_lt;
    logic          ex_ne;
    logic          ex_v;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_memtoreg;
    logic          ex_slt;
    logic          ex_bne;
    logic          ex_trap_v;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_br_target;
    logic          mem_valid;
    logic          mem_regwrite;
    logic          mem_memread;
    logic          mem_memwrite;
    logic          mem_memtoreg;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          pc_redirect;
    logic [DW-1:0] redirect_target;
    logic          exc_flag;
    logic [DW-1:0] exc_pc;

    logic [OW-1:0] obs_v;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] msk_q[$];
    out_t          last_e;
    out_t          last_m;
    int            checks;
    int            errors;

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_alu_out      (ex_alu_out),
        .ex_lt           (ex_lt),
        .ex_ne           (ex_ne),
        .ex_v            (ex_v),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_regwrite     (ex_regwrite),
        .ex_memread      (ex_memread),
        .ex_memwrite     (ex_memwrite),
        .ex_memtoreg     (ex_memtoreg),
        .ex_slt          (ex_slt),
        .ex_bne          (ex_bne),
        .ex_trap_v       (ex_trap_v),
        .ex_pc           (ex_pc),
        .ex_br_target    (ex_br_target),
        .mem_valid       (mem_valid),
        .mem_regwrite    (mem_regwrite),
        .mem_memread     (mem_memread),
        .mem_memwrite    (mem_memwrite),
        .mem_memtoreg    (mem_memtoreg),
        .mem_result      (mem_result),
        .mem_store_data  (mem_store_data),
        .mem_rd          (mem_rd),
        .pc_redirect     (pc_redirect),
        .redirect_target (redirect_target),
        .exc_flag        (exc_flag),
        .exc_pc          (exc_pc)
    );

    assign obs_v = {mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg,
                    mem_result, mem_store_data, mem_rd, pc_redirect, redirect_target,
                    exc_flag, exc_pc};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic drive_idle();
        stall = 0; flush = 0; ex_valid = 0; ex_alu_out = '0; ex_lt = 0; ex_ne = 0;
        ex_v = 0; ex_store_data = '0; ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
        ex_memwrite = 0; ex_memtoreg = 0; ex_slt = 0; ex_bne = 0; ex_trap_v = 0;
        ex_pc = '0; ex_br_target = '0;
    endtask

    task automatic drive_add(input logic [DW-1:0] a, input logic [RW-1:0] rd);
        ex_valid = 1; ex_alu_out = a; ex_rd = rd; ex_regwrite = 1;
    endtask

    task automatic push(input out_t e, input out_t m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        last_e = e;
        last_m = m;
    endtask

    // Expected word with everything zero except the sticky exception state.
    function automatic out_t base_exp();
        out_t e;
        e = '0;
        e.exc = last_e.exc;
        e.epc = last_e.epc;
        return e;
    endfunction

    // Data fields are don't-care behind a bubble; the target is don't-care
    // when no redirect is signalled.
    function automatic out_t mk_mask(input bit bubble, input bit redir);
        out_t m;
        m = '1;
        if (bubble) begin
            m.result = '0; m.sdata = '0; m.rd = '0;
        end
        if (!redir) m.tgt = '0;
        return m;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [OW-1:0] ev_, mv_;
        out_t e;
        drive_idle();
        rst = 1; ex_valid = 1; ex_alu_out = 16'hFFFF; ex_bne = 1; ex_ne = 1;
        ex_br_target = 16'h1111; ex_trap_v = 1; ex_v = 1; ex_pc = 16'h2222;
        e = '0;
        push(e, '1);
        @(posedge clk); #1;
        ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
        checks++;
        if ((obs_v & mv_) !== (ev_ & mv_)) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h", obs_v, ev_);
        end
        rst = 0;
        drive_idle();
    endtask

    task automatic test_add();
        logic [OW-1:0] ev_, mv_;
        out_t e;
        drive_idle();
        drive_add(16'h1234, 3'd5);
        ex_store_data = 16'hBEEF;
        e = base_exp();
        e.valid = 1; e.regwrite = 1; e.result = 16'h1234; e.sdata = 16'hBEEF; e.rd = 3'd5;
        push(e, mk_mask(0, 0));
        @(posedge clk); #1;
        ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
        checks++;
        if ((obs_v & mv_) !== (ev_ & mv_)) begin
            errors++;
            $display("FAIL add obs=%h exp=%h", obs_v, ev_);
        end
    endtask

    task automatic test_slt();
        logic [OW-1:0] ev_, mv_;
        out_t e;
        for (int s = 0; s < 3; s++) begin
            drive_idle();
            drive_add(16'h0000, 3'd2);
            ex_slt = 1;
            e = base_exp();
            e.valid = 1; e.regwrite = 1; e.rd = 3'd2;
            case (s)
                0: begin ex_lt = 1; e.result = 16'h0001; end
                1: begin ex_lt = 0; e.result = 16'h0000; end
                default: begin ex_lt = 1; ex_alu_out = 16'hFF00; e.result = 16'h0001; end
            endcase
            push(e, mk_mask(0, 0));
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL slt step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
    endtask

    task automatic test_bne();
        logic [OW-1:0] ev_, mv_;
        out_t e, m;
        for (int s = 0; s < 4; s++) begin
            drive_idle();
            e = base_exp();
            case (s)
                0: begin  // taken: controls zeroed, pulse with target
                    ex_valid = 1; ex_bne = 1; ex_ne = 1; ex_br_target = 16'h0040;
                    ex_regwrite = 1; ex_memread = 1; ex_memwrite = 1; ex_rd = 3'd3;
                    e.valid = 1; e.rd = 3'd3; e.redir = 1; e.tgt = 16'h0040;
                    m = mk_mask(0, 1);
                end
                1: begin  // wrong-path instruction squashed, pulse ends
                    drive_add(16'h5555, 3'd4);
                    m = mk_mask(1, 0);
                end
                2: begin  // not taken: valid but no writes, no pulse
                    ex_valid = 1; ex_bne = 1; ex_ne = 0; ex_regwrite = 1; ex_rd = 3'd1;
                    ex_br_target = 16'h0099;
                    e.valid = 1; e.rd = 3'd1;
                    m = mk_mask(0, 0);
                end
                default: begin
                    drive_add(16'h5555, 3'd4);
                    e.valid = 1; e.regwrite = 1; e.result = 16'h5555; e.rd = 3'd4;
                    m = mk_mask(0, 0);
                end
            endcase
            push(e, m);
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL bne step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
    endtask

    task automatic test_stall_redirect();
        logic [OW-1:0] ev_, mv_;
        out_t e, m;
        for (int s = 0; s < 5; s++) begin
            drive_idle();
            e = base_exp();
            case (s)
                0: begin
                    ex_valid = 1; ex_bne = 1; ex_ne = 1; ex_br_target = 16'h0080; ex_rd = 3'd6;
                    e.valid = 1; e.rd = 3'd6; e.redir = 1; e.tgt = 16'h0080;
                    m = mk_mask(0, 1);
                end
                1, 2: begin  // stalled: everything holds, even with flush
                    stall = 1; flush = (s == 2);
                    drive_add(16'h7777, 3'd7);
                    e = last_e; m = last_m;
                end
                3: begin
                    drive_add(16'h7777, 3'd7);
                    m = mk_mask(1, 0);
                end
                default: begin
                    drive_add(16'h7777, 3'd7);
                    e.valid = 1; e.regwrite = 1; e.result = 16'h7777; e.rd = 3'd7;
                    m = mk_mask(0, 0);
                end
            endcase
            push(e, m);
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL stall_redirect step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
    endtask

    task automatic test_overflow();
        logic [OW-1:0] ev_, mv_;
        out_t e;
        for (int s = 0; s < 4; s++) begin
            drive_idle();
            drive_add(16'h8000, 3'd7);
            ex_memread = 1; ex_memwrite = 1;
            e = base_exp();
            e.valid = 1; e.memread = 1; e.result = 16'h8000; e.rd = 3'd7;
            case (s)
                0: begin
                    ex_trap_v = 1; ex_v = 1; ex_pc = 16'h0010;
                    e.exc = 1; e.epc = 16'h0010;
                end
                1: begin ex_trap_v = 1; ex_v = 1; ex_pc = 16'h0020; end
                2: begin
                    ex_trap_v = 1; ex_v = 0; ex_pc = 16'h0030;
                    e.regwrite = 1; e.memwrite = 1;
                end
                default: begin
                    ex_trap_v = 0; ex_v = 1; ex_pc = 16'h0040;
                    e.regwrite = 1; e.memwrite = 1;
                end
            endcase
            push(e, mk_mask(0, 0));
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL overflow step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
    endtask

    task automatic test_flush();
        logic [OW-1:0] ev_, mv_;
        out_t e, m;
        for (int s = 0; s < 4; s++) begin
            drive_idle();
            e = base_exp();
            case (s)
                0: begin
                    flush = 1; drive_add(16'h1357, 3'd1);
                    m = mk_mask(1, 0);
                end
                1: begin
                    drive_add(16'h2468, 3'd2); ex_memread = 1; ex_memtoreg = 1;
                    e.valid = 1; e.regwrite = 1; e.memread = 1; e.memtoreg = 1;
                    e.result = 16'h2468; e.rd = 3'd2;
                    m = mk_mask(0, 0);
                end
                2: begin
                    stall = 1; flush = 1; drive_add(16'h9999, 3'd3);
                    e = last_e; m = last_m;
                end
                default: begin
                    m = mk_mask(1, 0);
                end
            endcase
            push(e, m);
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL flush step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
    endtask

    task automatic test_reset_mid_redirect();
        logic [OW-1:0] ev_, mv_;
        out_t e, m;
        for (int s = 0; s < 3; s++) begin
            drive_idle();
            e = base_exp();
            case (s)
                0: begin
                    ex_valid = 1; ex_bne = 1; ex_ne = 1; ex_br_target = 16'h0044; ex_rd = 3'd5;
                    e.valid = 1; e.rd = 3'd5; e.redir = 1; e.tgt = 16'h0044;
                    m = mk_mask(0, 1);
                end
                1: begin
                    rst = 1; stall = 1; drive_add(16'hAAAA, 3'd6);
                    e = '0; m = '1;
                end
                default: begin
                    rst = 0; drive_add(16'h0F0F, 3'd5);
                    e = '0;
                    e.valid = 1; e.regwrite = 1; e.result = 16'h0F0F; e.rd = 3'd5;
                    m = mk_mask(0, 0);
                end
            endcase
            push(e, m);
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL reset_redirect step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
        rst = 0;
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] ev_, mv_;
        out_t e, m;
        for (int s = 0; s < 24; s++) begin
            drive_idle();
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 4) == 0);
            ex_valid      = ($urandom_range(0, 5) != 0);
            ex_alu_out    = DW'($urandom_range(0, 65535));
            ex_store_data = DW'($urandom_range(0, 65535));
            ex_rd         = RW'($urandom_range(0, 7));
            ex_regwrite   = 1'($urandom_range(0, 1));
            ex_memread    = 1'($urandom_range(0, 1));
            ex_memwrite   = 1'($urandom_range(0, 1));
            ex_memtoreg   = 1'($urandom_range(0, 1));
            ex_slt        = 1'($urandom_range(0, 1));
            ex_lt         = 1'($urandom_range(0, 1));
            ex_v          = 1'($urandom_range(0, 1));
            ex_pc         = DW'($urandom_range(0, 65535));
            e = base_exp();
            if (stall) begin
                e = last_e; m = last_m;
            end else if (!ex_valid || flush) begin
                m = mk_mask(1, 0);
            end else begin
                e.valid = 1; e.regwrite = ex_regwrite; e.memread = ex_memread;
                e.memwrite = ex_memwrite; e.memtoreg = ex_memtoreg;
                e.result = ex_slt ? {{(DW-1){1'b0}}, ex_lt} : ex_alu_out;
                e.sdata = ex_store_data; e.rd = ex_rd;
                m = mk_mask(0, 0);
            end
            push(e, m);
            @(posedge clk); #1;
            ev_ = exp_q.pop_front(); mv_ = msk_q.pop_front();
            checks++;
            if ((obs_v & mv_) !== (ev_ & mv_)) begin
                errors++;
                $display("FAIL back_to_back step %0d obs=%h exp=%h", s, obs_v, ev_);
            end
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        last_e = '0;
        last_m = '1;
        rst = 1;
        drive_idle();
        test_reset();
        test_add();
        test_slt();
        test_bne();
        test_stall_redirect();
        test_overflow();
        test_flush();
        test_reset_mid_redirect();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
